cic_decim_iq: RTL and testbench

- Parametrised, dual-channel (I/Q) N-stage CIC decimator, the successor to the fixed 5-stage single-channel CIC.
- Adds stage count and differential delay as generics, a runtime-programmable decimation ratio, an input-valid strobe, and a pipelined comb section.
- Adds a registered, saturating gain stage with an overflow flag.
- Sits between the I/Q mixer outputs and the demodulator/low-rate filter chain.

---
 rtl/cic_decim_iq.sv | 182 ++++++++++++++++++
 tb/tb_cic_decim_iq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_iq.sv
// Dual-channel (I/Q) N-stage CIC decimator: runtime decimation ratio, input strobe,
// pipelined comb section and a registered saturating gain stage with overflow flag.
module cic_decim_iq #(
    parameter int STAGES     = 5,
    parameter int DIFF_DELAY = 1,
    parameter int BITS       = 16,
    parameter int WIDTH      = 76,
    parameter int DECIM_BITS = 16,
    parameter int GAIN_BITS  = 8
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic signed [BITS-1:0]       x_i,
    input  logic signed [BITS-1:0]       x_q,
    input  logic                         in_valid,
    input  logic        [DECIM_BITS-1:0] decim,
    input  logic        [GAIN_BITS-1:0]  gain,
    output logic signed [BITS-1:0]       x_out_i,
    output logic signed [BITS-1:0]       x_out_q,
    output logic                         out_tick,
    output logic                         overflow
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {{(WIDTH-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {{(WIDTH-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    localparam logic signed [BITS-1:0]  OUT_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0]  OUT_MIN = {1'b1, {(BITS-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] v,
                                                      input logic [GAIN_BITS-1:0] g);
        int sh;
        sh = WIDTH - BITS - int'(g);
        if (sh < 0) sh = 0;
        return v >>> sh;
    endfunction

    function automatic logic is_clip(input logic signed [WIDTH-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [BITS-1:0] saturate(input logic signed [WIDTH-1:0] v);
        if (v > SAT_MAX) return OUT_MAX;
        if (v < SAT_MIN) return OUT_MIN;
        return v[BITS-1:0];
    endfunction

    logic signed [BITS-1:0]  x_in [2];
    logic signed [BITS-1:0]  sat_val [2];
    logic                    clip [2];
    logic [DECIM_BITS-1:0]   cnt;
    logic [DECIM_BITS-1:0]   r_active;
    logic [DECIM_BITS-1:0]   r_eff;
    logic [DECIM_BITS-1:0]   decim_clamped;
    logic                    load_pending;
    logic                    sample_evt;
    logic                    vld_p [STAGES+1];
    logic [GAIN_BITS-1:0]    gain_p [STAGES+1];

    assign x_in[0] = x_i;
    assign x_in[1] = x_q;

    // A ratio change only lands at a block boundary; the first block after reset takes decim live
    always_comb begin
        decim_clamped = (decim < DECIM_BITS'(2)) ? DECIM_BITS'(2) : decim;
        r_eff         = load_pending ? decim_clamped : r_active;
        sample_evt    = in_valid && (cnt == r_eff - DECIM_BITS'(1));
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cnt          <= '0;
            r_active     <= '0;
            load_pending <= 1'b1;
        end else if (in_valid) begin
            load_pending <= 1'b0;
            if (sample_evt) begin
                cnt      <= '0;
                r_active <= decim_clamped;
            end else begin
                cnt      <= cnt + DECIM_BITS'(1);
                r_active <= r_eff;
            end
        end
    end

    // Stage p0: sample event; valid and captured gain enter the comb pipeline
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            vld_p[0]  <= 1'b0;
            gain_p[0] <= '0;
        end else begin
            vld_p[0] <= sample_evt;
            if (sample_evt) gain_p[0] <= gain;
        end
    end

    // Stages p1..pSTAGES: valid/gain ride alongside the comb data
    for (genvar k = 1; k <= STAGES; k++) begin : g_vld
        always_ff @(posedge CLK or negedge RSTb) begin
            if (!RSTb) begin
                vld_p[k]  <= 1'b0;
                gain_p[k] <= '0;
            end else begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) gain_p[k] <= gain_p[k-1];
            end
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic signed [WIDTH-1:0] x_ext;
        logic signed [WIDTH-1:0] integ [STAGES];
        logic signed [WIDTH-1:0] comb_p [STAGES+1];
        logic signed [WIDTH-1:0] scaled_p;

        assign x_ext = {{(WIDTH-BITS){x_in[c][BITS-1]}}, x_in[c]};

        // Integrators wrap modulo 2^WIDTH; the comb differences undo the wrap
        for (genvar k = 0; k < STAGES; k++) begin : g_int
            if (k == 0) begin : g_first
                always_ff @(posedge CLK or negedge RSTb) begin
                    if (!RSTb)         integ[0] <= '0;
                    else if (in_valid) integ[0] <= integ[0] + x_ext;
                end
            end else begin : g_rest
                always_ff @(posedge CLK or negedge RSTb) begin
                    if (!RSTb)         integ[k] <= '0;
                    else if (in_valid) integ[k] <= integ[k] + integ[k-1];
                end
            end
        end

        // Stage p0: pre-update value of the last integrator
        always_ff @(posedge CLK or negedge RSTb) begin
            if (!RSTb)           comb_p[0] <= '0;
            else if (sample_evt) comb_p[0] <= integ[STAGES-1];
        end

        // Stages p1..pSTAGES: one comb per stage, each with its own M-deep delay line
        for (genvar k = 1; k <= STAGES; k++) begin : g_comb
            logic signed [WIDTH-1:0] dly_a;
            logic signed [WIDTH-1:0] dly_b;
            logic signed [WIDTH-1:0] tap;

            assign tap = (DIFF_DELAY == 2) ? dly_b : dly_a;

            always_ff @(posedge CLK or negedge RSTb) begin
                if (!RSTb) begin
                    comb_p[k] <= '0;
                    dly_a     <= '0;
                    dly_b     <= '0;
                end else if (vld_p[k-1]) begin
                    comb_p[k] <= comb_p[k-1] - tap;
                    dly_a     <= comb_p[k-1];
                    dly_b     <= dly_a;
                end
            end
        end

        assign scaled_p   = scale(comb_p[STAGES], gain_p[STAGES]);
        assign sat_val[c] = saturate(scaled_p);
        assign clip[c]    = is_clip(scaled_p);
    end

    // Output stage: shift, saturate and register; overflow only accompanies a tick
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            x_out_i  <= '0;
            x_out_q  <= '0;
            out_tick <= 1'b0;
            overflow <= 1'b0;
        end else begin
            out_tick <= vld_p[STAGES];
            overflow <= vld_p[STAGES] && (clip[0] || clip[1]);
            if (vld_p[STAGES]) begin
                x_out_i <= sat_val[0];
                x_out_q <= sat_val[1];
            end
        end
    end

endmodule

// File: tb/tb_cic_decim_iq.sv
// Directed bench for cic_decim_iq: a reference model queues the expected result of every
// block when its last input is driven; each out_tick pops and checks value and latency.
module tb_cic_decim_iq;

    localparam int STAGES     = 5;
    localparam int BITS       = 16;
    localparam int WIDTH      = 32;
    localparam int DECIM_BITS = 16;
    localparam int GAIN_BITS  = 8;
    localparam longint OMAX   = (64'sd1 <<< (BITS-1)) - 1;
    localparam longint OMIN   = -OMAX - 1;

    logic                         CLK = 1'b0;
    logic                         RSTb = 1'b0;
    logic signed [BITS-1:0]       x_i = '0;
    logic signed [BITS-1:0]       x_q = '0;
    logic                         in_valid = 1'b0;
    logic        [DECIM_BITS-1:0] decim = 16'd4;
    logic        [GAIN_BITS-1:0]  gain = 8'd16;
    logic signed [BITS-1:0]       x_out_i;
    logic signed [BITS-1:0]       x_out_q;
    logic                         out_tick;
    logic                         overflow;

    cic_decim_iq #(
        .STAGES(STAGES), .DIFF_DELAY(1), .BITS(BITS), .WIDTH(WIDTH),
        .DECIM_BITS(DECIM_BITS), .GAIN_BITS(GAIN_BITS)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .x_i(x_i), .x_q(x_q), .in_valid(in_valid),
        .decim(decim), .gain(gain), .x_out_i(x_out_i), .x_out_q(x_out_q),
        .out_tick(out_tick), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int     e0;
        bit     chk;
        longint ei;
        longint eq;
        bit     eo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    int   m_r = 0;
    int   prev_r = 0;
    int   skip = 0;
    bit   m_pend = 1'b1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clamp_r(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Steady-state CIC response to a constant: x * R^N, shifted, then clipped
    function automatic longint ref_out(input longint x, input int r, input int g, output bit clipped);
        longint v;
        int     sh;
        v = x;
        for (int s = 0; s < STAGES; s++) v = v * r;
        sh = WIDTH - BITS - g;
        if (sh < 0) sh = 0;
        v = v >>> sh;
        clipped = 1'b0;
        if (v > OMAX) begin
            v = OMAX;
            clipped = 1'b1;
        end else if (v < OMIN) begin
            v = OMIN;
            clipped = 1'b1;
        end
        return v;
    endfunction

    task automatic observe();
        exp_t e;
        if (out_tick === 1'b1) begin
            check("tick_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("latency", cyc - e.e0, STAGES + 1);
                if (e.chk) begin
                    check("x_out_i", x_out_i, e.ei);
                    check("x_out_q", x_out_q, e.eq);
                    check("overflow", overflow, e.eo);
                end
            end
        end else begin
            check("ovf_idle", overflow, 0);
            if (sb.size() > 0) begin
                check("tick_missing", cyc < sb[0].e0 + STAGES + 1, 1);
                if (cyc >= sb[0].e0 + STAGES + 1) void'(sb.pop_front());
            end
        end
    endtask

    task automatic step();
        exp_t e;
        int   reff;
        bit   ci;
        bit   cq;
        @(posedge CLK);
        cyc++;
        if (RSTb && in_valid) begin
            reff   = m_pend ? clamp_r(int'(decim)) : m_r;
            m_pend = 1'b0;
            m_r    = reff;
            if (m_cnt == reff - 1) begin
                m_cnt = 0;
                m_r   = clamp_r(int'(decim));
                if (reff != prev_r) skip = STAGES;
                prev_r = reff;
                e.e0  = cyc;
                e.chk = (skip == 0);
                if (skip > 0) skip--;
                e.ei = ref_out(x_i, reff, int'(gain), ci);
                e.eq = ref_out(x_q, reff, int'(gain), cq);
                e.eo = ci | cq;
                sb.push_back(e);
            end else begin
                m_cnt++;
            end
        end
        #1;
        observe();
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_r    = 0;
        prev_r = 0;
        skip   = 0;
        m_pend = 1'b1;
    endtask

    task automatic do_reset(input int dec, input int gn);
        RSTb     = 1'b0;
        in_valid = 1'b0;
        decim    = DECIM_BITS'(dec);
        gain     = GAIN_BITS'(gn);
        model_reset();
        step();
        step();
        check("rst_x_out_i", x_out_i, 0);
        check("rst_x_out_q", x_out_q, 0);
        check("rst_out_tick", out_tick, 0);
        check("rst_overflow", overflow, 0);
        RSTb = 1'b1;
    endtask

    task automatic run(input int n);
        in_valid = 1'b1;
        repeat (n) step();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (STAGES + 4) step();
        check("queue_drained", sb.size(), 0);
    endtask

    initial begin
        // Unity input, ratio 4, shift 0
        do_reset(4, 16);
        x_i = 16'sd1;
        x_q = -16'sd1;
        run(40);
        drain();

        // Full-scale input clips on both channels
        do_reset(4, 16);
        x_i = 16'sd32767;
        x_q = 16'h8000;
        run(40);
        drain();

        // gain=6 gives shift 10
        do_reset(4, 6);
        x_i = 16'sd1024;
        x_q = -16'sd1024;
        run(40);
        drain();

        // Sparse input strobe: one accepted sample every 3 cycles
        do_reset(4, 16);
        x_i = 16'sd1;
        x_q = -16'sd1;
        for (int n = 0; n < 60; n++) begin
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            step();
        end
        drain();

        // Ratio 4 -> 8 two inputs into a block
        do_reset(4, 16);
        x_i = 16'sd1;
        x_q = -16'sd1;
        run(32);
        run(2);
        decim = 16'd8;
        run(80);
        drain();

        // Ratio 0 behaves as 2
        do_reset(0, 16);
        run(40);
        drain();

        // Asynchronous reset between clock edges with a sample in flight
        do_reset(4, 16);
        run(40);
        for (int n = 0; n < 8 && sb.size() == 0; n++) step();
        check("in_flight_before_reset", sb.size() > 0, 1);
        #2;
        RSTb = 1'b0;
        #1;
        check("async_x_out_i", x_out_i, 0);
        check("async_x_out_q", x_out_q, 0);
        check("async_out_tick", out_tick, 0);
        check("async_overflow", overflow, 0);
        model_reset();
        decim = 16'd2;
        step();
        step();
        RSTb = 1'b1;
        run(30);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
